// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised RAM family.
//   ram_state_t     - clear-sequencer state (CLEAR, RUN)
//   RAM_WIDTH_DEF   - default data word width
//   RAM_ADDR_W_DEF  - default address width (DEPTH = 2**ADDR_W)
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  localparam int RAM_WIDTH_DEF  = 16;
  localparam int RAM_ADDR_W_DEF = 14;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer for ram_param.
// Walks a pointer over every word, asking the array to write zero, then
// moves to RUN and reports done.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   busy     out  high while the clear sequence owns the array write port
//   clr_addr out  word address being cleared
//   clr_we   out  write strobe for the clear (suppressed while reset held)
//   done     out  clear finished, RAM is usable
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // The pointer stops at the last word and leaves CLEAR on that same edge,
  // so it never wraps while the sequence is still running.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == CLEAR) begin
      if (addr_q == LAST_ADDR) begin
        state_d = RUN;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy && !reset;
  assign clr_addr = addr_q;
  assign done     = (state_q == RUN);

endmodule

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with registered read data and a
// built-in clear sequence after every reset.
// Parameters: WIDTH (data bits), ADDR_W (address bits, DEPTH = 2**ADDR_W).
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   value      in   write data
//   load       in   write enable
//   address    in   word address
//   out        out  registered read data (write-first on write edges)
//   ready      out  clear finished, accesses accepted
//   parity_err out  read parity mismatch (constant 0 unless PARITY_EN)
// Build option: define PARITY_EN to store an even-parity bit per word and
// flag mismatches on reads.
module ram_param
  import ram_pkg::*;
#(
  parameter int WIDTH  = RAM_WIDTH_DEF,
  parameter int ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  output logic              ready,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  logic              busy;
  logic              clr_we;
  logic              done;
  logic [ADDR_W-1:0] clr_addr;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;

  logic [MEM_W-1:0]  mem [0:DEPTH-1];

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we),
    .done     (done)
  );

  // While clearing, the sequencer owns the write port; user writes are
  // dropped during reset so the array is untouched while reset is held.
  always_comb begin
    mem_we    = busy ? clr_we : (load && !reset);
    mem_addr  = busy ? clr_addr : address;
    mem_wdata = '0;
    if (!busy) begin
`ifdef PARITY_EN
      mem_wdata = {^value, value};
`else
      mem_wdata = value;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign rd_word = mem[address];

  // Read stage: one-cycle latency, write-first on write edges.
  always_ff @(posedge clk) begin
    if (reset || busy) begin
      out <= '0;
    end else if (load) begin
      out <= value;
    end else begin
      out <= rd_word[WIDTH-1:0];
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk) begin
    if (reset || busy || load) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (^rd_word[WIDTH-1:0]) != rd_word[WIDTH];
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign ready = done;

endmodule

// File: tb/tb_ram_param.sv
module tb_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: ADDR_W=4 (DEPTH 16)
  logic        reset4, load4;
  logic [15:0] value4, out4;
  logic [3:0]  addr4;
  logic        ready4, perr4;

  // Default instance: ADDR_W=14
  logic        resetl, loadl;
  logic [15:0] valuel, outl;
  logic [13:0] addrl;
  logic        readyl, perrl;

  int total = 0;
  int bad   = 0;

  logic [15:0] model4 [0:15];
  logic [15:0] exp_out;

  ram_param #(.WIDTH(16), .ADDR_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset4),
    .value      (value4),
    .load       (load4),
    .address    (addr4),
    .out        (out4),
    .ready      (ready4),
    .parity_err (perr4)
  );

  ram_param dutl (
    .clk        (clk),
    .reset      (resetl),
    .value      (valuel),
    .load       (loadl),
    .address    (addrl),
    .out        (outl),
    .ready      (readyl),
    .parity_err (perrl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset4 = 1'b1; load4 = 1'b0; value4 = '0; addr4 = '0;
    resetl = 1'b1; loadl = 1'b0; valuel = '0; addrl = '0;

    // Reset sequencing: reset held 2 cycles
    step();
    step();
    check("reset_ready", ready4, 0);
    check("reset_out", out4, 0);

    // Release; attempt a write during clear that must be ignored
    reset4 = 1'b0;
    load4 = 1'b1; addr4 = 4'd5; value4 = 16'hABCD;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("clr1_ready_e%0d", i), ready4, (i == 16));
      check($sformatf("clr1_out_e%0d", i), out4, 0);
    end
    for (int a = 0; a < 16; a++) model4[a] = '0;

    // Ignore during clear: address 5 reads back 0
    load4 = 1'b0; addr4 = 4'd5;
    step();
    check("ignore_clear_rd5", out4, 0);

    // Preload every word with FFFF; out is write-first
    for (int a = 0; a < 16; a++) begin
      load4 = 1'b1; addr4 = a[3:0]; value4 = 16'hFFFF;
      step();
      model4[a] = 16'hFFFF;
      check($sformatf("preload_out_a%0d", a), out4, 16'hFFFF);
    end
    load4 = 1'b0;

    // Reset one cycle in RUN
    reset4 = 1'b1;
    step();
    check("run_reset_ready", ready4, 0);
    check("run_reset_out", out4, 0);
    reset4 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("clr2_ready_e%0d", i), ready4, (i == 16));
    end
    for (int a = 0; a < 16; a++) model4[a] = '0;

    // Clear coverage: every word reads 0
    for (int a = 0; a < 16; a++) begin
      addr4 = a[3:0];
      step();
      check($sformatf("clear_cov_a%0d", a), out4, model4[a]);
    end

    // Reset mid-clear at clear cycle 7
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    check("midclr_ready_c7", ready4, 0);
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("clr3_ready_e%0d", i), ready4, (i == 16));
    end

    // Same-address write then read
    load4 = 1'b1; addr4 = 4'd9; value4 = 16'h1234;
    step();
    model4[9] = 16'h1234;
    check("wr9_out", out4, 16'h1234);
    load4 = 1'b0;
    step();
    check("rd9_out", out4, 16'h1234);

    // Randomized traffic against the array model
    for (int n = 0; n < 300; n++) begin
      load4  = ($urandom_range(0, 2) == 0);
      addr4  = 4'($urandom_range(0, 15));
      value4 = 16'($urandom);
      if (load4) begin
        exp_out = value4;
        model4[addr4] = value4;
      end else begin
        exp_out = model4[addr4];
      end
      step();
      check($sformatf("rand_out_n%0d", n), out4, exp_out);
      check($sformatf("rand_perr_n%0d", n), perr4, 0);
    end
    load4 = 1'b0;

`ifdef PARITY_EN
    // Parity: corrupt one stored bit and read it back
    load4 = 1'b1; addr4 = 4'd2; value4 = 16'h0007;
    step();
    check("par_wr_perr", perr4, 0);
    load4 = 1'b0;
    dut4.mem[2][0] = ~dut4.mem[2][0];
    addr4 = 4'd2;
    step();
    check("par_corrupt_perr", perr4, 1);
    check("par_corrupt_out", out4, 16'h0006);
    addr4 = 4'd3;
    step();
    check("par_clean_perr", perr4, 0);
`endif

    // Default-size instance: full clear then latency checks
    resetl = 1'b1;
    step();
    check("big_reset_ready", readyl, 0);
    resetl = 1'b0;
    for (int i = 1; i <= 16384; i++) begin
      step();
      if (i == 16383) check("big_ready_e16383", readyl, 0);
      if (i == 16384) check("big_ready_e16384", readyl, 1);
    end
    loadl = 1'b1; addrl = 14'd4739; valuel = 16'h0003;
    step();
    check("big_wr4739_out", outl, 16'h0003);
    addrl = 14'd10861; valuel = 16'h000F;
    step();
    check("big_wr10861_out", outl, 16'h000F);
    loadl = 1'b0; addrl = 14'd4739;
    step();
    check("big_rd4739", outl, 16'h0003);
    addrl = 14'd10861;
    step();
    check("big_rd10861", outl, 16'h000F);
    addrl = 14'd100;
    step();
    check("big_rd100", outl, 16'h0000);
    check("big_perr", perrl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
- Parametrised single-port synchronous RAM; next-generation replacement for the fixed-size ram16k in the memory-units library.
- Width and depth are generic.
- Read data is registered.
- After every reset, a built-in clear sequencer zeroes the whole array and then raises a ready flag.
- Sits between the CPU data bus and the address decoder, the same place ram16k occupies.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_W, 14, address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  WIDTH  write data.
- load  input  1  write enable; sampled on rising clk.
- address  input  ADDR_W  word address for read and write.
- out  output  WIDTH  registered read data.
- ready  output  1  high when the clear sequence is finished and the RAM accepts accesses.
- parity_err  output  1  read-data parity mismatch flag; tied 0 unless PARITY_EN is defined.

Behaviour:
- FSM states: CLEAR, RUN.
- Reset (reset=1 at a rising edge):
  - State goes to CLEAR, clear pointer clr_addr=0.
  - ready=0, out=0, parity_err=0.
  - Memory contents are not touched while reset is held.
- CLEAR state (reset=0):
  - Each edge writes 0 to mem[clr_addr], then clr_addr+1.
  - The edge that writes DEPTH-1 moves the state to RUN and sets ready=1.
  - ready therefore rises exactly DEPTH edges after the first edge with reset=0.
  - load, value and address are ignored; out holds 0.
- RUN state:
  - load=1 at an edge: mem[address]<=value, and out<=value on the same edge (write-first, 1-cycle latency).
  - load=0 at an edge: out<=mem[address] (1-cycle read latency).
  - Address changes between edges have no effect until the next edge; out never changes combinationally.
- Reset mid-CLEAR: clr_addr restarts at 0; a full DEPTH-cycle clear follows.
- Reset in RUN: state returns to CLEAR; ready drops on that edge and all data is cleared again.
- Clear pointer width is ADDR_W; it must not wrap before the state transition.
- Same-address write then read on consecutive edges returns the newly written value.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - Array widens to WIDTH+1; the extra bit stores the even parity (XOR) of written data.
  - The clear sequence writes parity 0 with data 0.
  - On each read edge in RUN, parity_err<=(XOR of stored data) != stored parity bit.
  - parity_err is registered alongside out, holds until the next read or write edge, and is forced 0 on write edges and in CLEAR.
  - Storage array is named mem so the bench can corrupt a word hierarchically.
- Not defined:
  - Array is WIDTH bits.
  - parity_err is constant 0.
  - No extra logic.

Decomposition:
- Shared package ram_pkg:
  - state typedef (CLEAR, RUN).
  - Default constants RAM_WIDTH_DEF=16 and RAM_ADDR_W_DEF=14, reused by the future ram_param-based memory map.
- One sub-module, ram_clear_seq, with:
  - ports clk, reset, busy, clr_addr, clr_we, done;
  - the FSM and pointer.
- ram_param muxes clr_addr/clr_we/0 into the array write port while busy.

Test Plan:
- Reset sequencing, ADDR_W=4, WIDTH=16:
  - Stimulus: reset high 2 cycles, then low.
  - Required: ready stays 0 for exactly 16 edges, goes 1 on the 16th; out=0 throughout.
- Clear coverage:
  - Stimulus: preload every word with 16'hFFFF via writes in RUN, assert reset 1 cycle, wait for ready, read all 16 addresses.
  - Required: every read returns 0.
- Write/read latency, default parameters:
  - Stimulus: write 16'h0003 to 4739 and 16'h000F to 10861, then read 4739 and 10861.
  - Required: out=16'h0003 one edge after the first read, 16'h000F one edge after the second read.
  - Required: out equals the written value on each write edge.
- Ignore during CLEAR:
  - Stimulus: load=1, address=5, value=16'hABCD while ready=0.
  - Required: after ready, read address 5 returns 0.
- Reset mid-clear, ADDR_W=4:
  - Stimulus: reset at clear cycle 7.
  - Required: ready rises 16 edges after reset deasserts, not 9.
- PARITY_EN:
  - Stimulus: write 16'h0007 to address 2, flip mem[2][0] hierarchically, read address 2.
  - Required: parity_err=1 one edge later.
  - Required: reading an uncorrupted address gives parity_err=0.
